// File: rtl/rv32_multicycle_core.sv
// Multicycle RV32I core: FETCH_INSTR -> FETCH_REGS -> EXECUTE, with an internal program ROM,
// RUN gating for free-run/single-step, and a terminal HALT state reached by EBREAK or a trap.
module rv32_multicycle_core #(
    parameter int          MEM_WORDS  = 256,
    parameter string       INIT_FILE  = "prog.hex",
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          RET_W      = 16,
    parameter int          DBG_REG_ID = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic [1:0]       state,
    output logic [31:0]      pc,
    output logic             halted,
    output logic             illegal,
    output logic [RET_W-1:0] retired,
    output logic [31:0]      dbg_reg
);
    localparam int          AW         = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;
    localparam logic [6:0]  OP_ALUREG  = 7'b0110011;
    localparam logic [6:0]  OP_ALUIMM  = 7'b0010011;
    localparam logic [6:0]  OP_LUI     = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC   = 7'b0010111;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [6:0]  OP_JALR    = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]  OP_SYSTEM  = 7'b1110011;
    localparam logic [4:0]  DBG_IDX    = DBG_REG_ID[4:0];

    typedef enum logic [1:0] {
        FETCH_INSTR = 2'd0,
        FETCH_REGS  = 2'd1,
        EXECUTE     = 2'd2,
        HALT        = 2'd3
    } state_t;

    state_t      st;
    logic [31:0] rom  [0:MEM_WORDS-1];
    logic [31:0] regs [0:31];
    logic [31:0] instr, rs1, rs2;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_id, rs1_id, rs2_id;
    logic [31:0] imm_i, imm_b, imm_j, imm_u, pc_plus4;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rd_id    = instr[11:7];
    assign rs1_id   = instr[19:15];
    assign rs2_id   = instr[24:20];
    assign imm_i    = {{21{instr[31]}}, instr[30:20]};
    assign imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign pc_plus4 = pc + 32'd4;

    logic [31:0] alu_in2, alu_out;
    logic [4:0]  shamt;

    // SUB only exists for register-register ops; instr[30] on ADDI is just an immediate bit.
    always_comb begin
        alu_in2 = (opcode == OP_ALUREG) ? rs2 : imm_i;
        shamt   = alu_in2[4:0];
        alu_out = 32'd0;
        case (funct3)
            3'b000: alu_out = (opcode == OP_ALUREG && instr[30]) ? rs1 - alu_in2 : rs1 + alu_in2;
            3'b001: alu_out = rs1 << shamt;
            3'b010: alu_out = {31'd0, $signed(rs1) < $signed(alu_in2)};
            3'b011: alu_out = {31'd0, rs1 < alu_in2};
            3'b100: alu_out = rs1 ^ alu_in2;
            3'b101: alu_out = instr[30] ? 32'($signed(rs1) >>> shamt) : rs1 >> shamt;
            3'b110: alu_out = rs1 | alu_in2;
            default: alu_out = rs1 & alu_in2;
        endcase
    end

    logic take, br_bad;

    always_comb begin
        take   = 1'b0;
        br_bad = 1'b0;
        case (funct3)
            3'b000: take = (rs1 == rs2);
            3'b001: take = (rs1 != rs2);
            3'b100: take = ($signed(rs1) < $signed(rs2));
            3'b101: take = ($signed(rs1) >= $signed(rs2));
            3'b110: take = (rs1 < rs2);
            3'b111: take = (rs1 >= rs2);
            default: br_bad = 1'b1;
        endcase
    end

    logic        legal, is_ebreak, wb_en;
    logic [31:0] wb_data, next_pc;

    // A misaligned next PC can only come from a jump or a taken branch, since PC itself stays aligned.
    always_comb begin
        legal     = 1'b1;
        is_ebreak = 1'b0;
        wb_en     = 1'b0;
        wb_data   = alu_out;
        next_pc   = pc_plus4;
        case (opcode)
            OP_ALUREG, OP_ALUIMM: wb_en = 1'b1;
            OP_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_data = pc_plus4; next_pc = pc + imm_j; end
            OP_JALR:   begin wb_en = 1'b1; wb_data = pc_plus4; next_pc = (rs1 + imm_i) & ~32'd1; end
            OP_BRANCH: begin
                if (br_bad) legal = 1'b0;
                else if (take) next_pc = pc + imm_b;
            end
            OP_SYSTEM: begin
                if (instr == EBREAK) is_ebreak = 1'b1;
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (next_pc[1:0] != 2'b00) legal = 1'b0;
    end

    // The bank has no reset; st is cleared asynchronously, so a reset aborts any pending write.
    always_ff @(posedge clk) begin
        if (st == EXECUTE && legal && !is_ebreak && wb_en && rd_id != 5'd0)
            regs[rd_id] <= wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= FETCH_INSTR;
            pc      <= RESET_PC;
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
            instr   <= NOP;
            rs1     <= 32'd0;
            rs2     <= 32'd0;
        end else begin
            case (st)
                FETCH_INSTR: begin
                    if (run) begin
                        instr <= rom[pc[AW+1:2]];
                        st    <= FETCH_REGS;
                    end
                end
                FETCH_REGS: begin
                    rs1 <= (rs1_id == 5'd0) ? 32'd0 : regs[rs1_id];
                    rs2 <= (rs2_id == 5'd0) ? 32'd0 : regs[rs2_id];
                    st  <= EXECUTE;
                end
                EXECUTE: begin
                    if (!legal) begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        st      <= HALT;
                    end else if (is_ebreak) begin
                        retired <= retired + RET_W'(1);
                        halted  <= 1'b1;
                        st      <= HALT;
                    end else begin
                        pc      <= next_pc;
                        retired <= retired + RET_W'(1);
                        st      <= FETCH_INSTR;
                    end
                end
                default: st <= HALT;
            endcase
        end
    end

    assign state = st;

    generate
        if (DBG_REG_ID == 0) begin : g_dbg_zero
            assign dbg_reg = 32'd0;
        end else begin : g_dbg_reg
            assign dbg_reg = regs[DBG_IDX];
        end
    endgenerate

endmodule
